// File: rtl/clashup_cpu_mc.sv
// Multi-cycle ClashUp CPU: runs a variable-length word stream from internal program RAM.
// Latency: one RAM word per cycle, an instruction of N words takes N+1 cycles.
// Flow control: host loads RAM only while idle/halted; out_valid is a one-cycle strobe.
module clashup_cpu_mc #(
  parameter int DW    = 8,
  parameter int NREGS = 8,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_wdata,
  input  logic          run,
  output logic [DW-1:0] out,
  output logic          out_valid,
  output logic          busy,
  output logic          halted,
  output logic [AW-1:0] pc_o
);

  localparam int RI = $clog2(NREGS);

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_SET  = 8'h01;
  localparam logic [7:0] OP_ADD  = 8'h02;
  localparam logic [7:0] OP_OUT  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_JMP  = 8'h05;
  localparam logic [7:0] OP_JZ   = 8'h06;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_OPA, S_OPB, S_EXEC, S_HALT
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc;
  logic [7:0]    op;
  logic [DW-1:0] a, b;
  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] mem  [2**AW];
  logic [DW-1:0] rdata;
  logic [RI-1:0] ia, ib;

  // Unknown opcodes fall through to "no operand", so they run as 1-word NOPs.
  function automatic logic has_operand(input logic [7:0] o);
    return (o == OP_SET) || (o == OP_ADD) || (o == OP_OUT) ||
           (o == OP_SUB) || (o == OP_JMP) || (o == OP_JZ);
  endfunction

  function automatic logic is_three_word(input logic [7:0] o);
    return (o == OP_SET) || (o == OP_ADD) || (o == OP_SUB) || (o == OP_JZ);
  endfunction

  assign rdata = mem[pc];
  assign ia    = a[RI-1:0];
  assign ib    = b[RI-1:0];
  assign pc_o  = pc;

  // Program RAM write port; no reset so the program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && (state == S_IDLE || state == S_HALT))
      mem[prog_addr] <= prog_wdata;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: operand count is decided from the word being fetched.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_FETCH;
      S_FETCH: state_nxt = has_operand(rdata[7:0]) ? S_OPA : S_EXEC;
      S_OPA:   state_nxt = is_three_word(op) ? S_OPB : S_EXEC;
      S_OPB:   state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:  if (run) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy   = (state == S_FETCH) || (state == S_OPA) ||
             (state == S_OPB)   || (state == S_EXEC);
    halted = (state == S_HALT);
  end

  // Datapath: registers are written only in EXEC, so a reset abort leaves no partial write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= '0;
      op        <= '0;
      a         <= '0;
      b         <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE, S_HALT: if (run) pc <= '0;
        S_FETCH: begin
          op <= rdata[7:0];
          pc <= pc + 1'b1;
        end
        S_OPA: begin
          a  <= rdata;
          pc <= pc + 1'b1;
        end
        S_OPB: begin
          b  <= rdata;
          pc <= pc + 1'b1;
        end
        S_EXEC: begin
          case (op)
            OP_SET: regs[ia] <= b;
            OP_ADD: regs[ia] <= regs[ia] + regs[ib];
            OP_SUB: regs[ia] <= regs[ia] - regs[ib];
            OP_OUT: begin
              out       <= regs[ia];
              out_valid <= 1'b1;
            end
            OP_JMP: pc <= AW'(a);
            OP_JZ:  if (regs[ia] == '0) pc <= AW'(b);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clashup_cpu_mc.sv
// Scoreboard bench for clashup_cpu_mc: expected OUT values (and their cycle) are queued
// when a program is started; a monitor pops and compares on every out_valid strobe.
// Cycle numbers are relative to the clk edge that samples run=1.
module tb_clashup_cpu_mc;

  logic       clk = 1'b0;
  logic       rst, prog_we, run;
  logic [7:0] prog_addr, prog_wdata;
  logic [7:0] out;
  logic       out_valid, busy, halted;
  logic [7:0] pc_o;

  clashup_cpu_mc #(.DW(8), .NREGS(8), .AW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .run        (run),
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .halted     (halted),
    .pc_o       (pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    int         c;    // expected relative cycle, -1 = any
    int         scn;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, t0 = 0, vectors = 0, miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] v, input int c, input int scn);
    exp_t e;
    e.v = v; e.c = c; e.scn = scn;
    sb.push_back(e);
  endtask

  // Monitor: every out_valid strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out: got strobe with out=0x%0h at cycle %0d, expected none", out, cyc - t0);
      end else begin
        e = sb.pop_front();
        check($sformatf("s%0d_out_value", e.scn), 32'(out), 32'(e.v));
        if (e.c >= 0) check($sformatf("s%0d_out_cycle", e.scn), 32'(cyc - t0), 32'(e.c));
      end
    end
  end

  task automatic load_word(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr; prog_wdata = data;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_halt(input string tag, input int exp_cyc, input logic [7:0] exp_pc);
    int n;
    n = 0;
    @(negedge clk);
    while (!halted && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_halt_timeout: got halted=0 after %0d cycles, expected halted=1", tag, n);
    end else begin
      if (exp_cyc >= 0) check({tag, "_halt_cycle"}, 32'(cyc - t0), 32'(exp_cyc));
      check({tag, "_busy_in_halt"}, 32'(busy), 32'd0);
      check({tag, "_pc_in_halt"}, 32'(pc_o), 32'(exp_pc));
    end
  endtask

  // Scenario programs (addresses start at 0).
  logic [7:0] p1 [12] = '{8'h01,8'h01,8'h05, 8'h01,8'h02,8'h07, 8'h02,8'h01,8'h02, 8'h03,8'h01, 8'hFF};
  logic [7:0] p2 [19] = '{8'h01,8'h00,8'hFF, 8'h01,8'h01,8'h02, 8'h02,8'h00,8'h01, 8'h03,8'h00,
                          8'h04,8'h00,8'h01, 8'h03,8'h00, 8'hFF, 8'h00, 8'h00};
  // L=6, E=16
  logic [7:0] p3 [17] = '{8'h01,8'h00,8'h03, 8'h01,8'h01,8'h01, 8'h04,8'h00,8'h01, 8'h03,8'h00,
                          8'h06,8'h00,8'h10, 8'h05,8'h06, 8'hFF};
  // OUT r0; SET r2,33; 7E; OUT r2; HALT
  logic [7:0] p5 [9]  = '{8'h03,8'h00, 8'h01,8'h02,8'h33, 8'h7E, 8'h03,8'h02, 8'hFF};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; prog_we = 1'b0; run = 1'b0; prog_addr = '0; prog_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", 32'(out), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_pc", 32'(pc_o), 32'd0);
    rst = 1'b0;

    // 1: basic, r1=5+7 -> 0x0C at cycle 15, halted from 17
    for (int i = 0; i < 12; i++) load_word(8'(i), p1[i]);
    push(8'h0C, 15, 1);
    start_run();
    wait_halt("s1", 17, 8'd12);

    // 2: wrap, FF+2=01 then 01-2=FF
    for (int i = 0; i < 19; i++) load_word(8'(i), p2[i]);
    push(8'h01, 15, 2);
    push(8'hFF, 22, 2);
    start_run();
    wait_halt("s2", 24, 8'd17);

    // 4: reset in OPA of the first SET; r0 (0xFF from s2) and out must clear
    for (int i = 0; i < 12; i++) load_word(8'(i), p1[i]);
    start_run();
    @(posedge clk); #1;
    check("s4_busy_before_rst", 32'(busy), 32'd1);
    check("s4_pc_in_opa", 32'(pc_o), 32'd1);
    rst = 1'b1;
    #2;
    check("s4_rst_out", 32'(out), 32'd0);
    check("s4_rst_busy", 32'(busy), 32'd0);
    check("s4_rst_halted", 32'(halted), 32'd0);
    check("s4_rst_pc", 32'(pc_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(8'h0C, 15, 4);
    start_run();
    wait_halt("s4", 17, 8'd12);

    // 5: OUT r0 shows regs were cleared; 7E is a 1-word NOP; write while busy is dropped
    for (int i = 0; i < 9; i++) load_word(8'(i), p5[i]);
    push(8'h00, 3, 5);
    push(8'h33, 12, 5);
    start_run();
    repeat (4) @(negedge clk);
    check("s5_busy_during_write", 32'(busy), 32'd1);
    prog_we = 1'b1; prog_addr = 8'h00; prog_wdata = 8'hFF;
    @(posedge clk); #1;
    prog_we = 1'b0;
    wait_halt("s5a", 14, 8'd9);
    push(8'h00, 3, 5);
    push(8'h33, 12, 5);
    start_run();
    wait_halt("s5b", 14, 8'd9);

    // 3: countdown loop 2,1,0 then HALT at 16
    for (int i = 0; i < 17; i++) load_word(8'(i), p3[i]);
    push(8'h02, -1, 3);
    push(8'h01, -1, 3);
    push(8'h00, -1, 3);
    start_run();
    wait_halt("s3", -1, 8'd17);

    // 6: JMP FE; SET r3 at FE with ra at FF and imm wrapping to addr 00 (=05);
    //    addr 01 (=FE) runs as a NOP, OUT r3 at 02 -> 05, HALT at 04
    load_word(8'h00, 8'h05);
    load_word(8'h01, 8'hFE);
    load_word(8'h02, 8'h03);
    load_word(8'h03, 8'h03);
    load_word(8'h04, 8'hFF);
    load_word(8'hFE, 8'h01);
    load_word(8'hFF, 8'h03);
    push(8'h05, 12, 6);
    start_run();
    wait_halt("s6", 14, 8'd5);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
